// File: rtl/piso_serializer.sv
// Purpose: parallel-in, serial-out transmitter; shifts a WIDTH-bit word out one bit per clock with valid and end-of-word strobes.
// Latency: first bit appears on dout one clock after the accepting edge; done marks the last bit (accept edge + WIDTH).
// Backpressure: load_ready is high in IDLE and on the last bit of a word only, allowing gapless back-to-back words; no queueing.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             last_bit;
    logic             xfer;

    // Handshake and status decode; derived from state only, never from load_valid.
    always_comb begin
        last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        load_ready = (state_q == IDLE) || last_bit;
        xfer       = load_valid && load_ready;
        busy       = (state_q == SHIFT);
        done       = last_bit;
    end

    // Next-state logic: load a new word on a transfer, else shift, else fall back to IDLE after the last bit.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (xfer) begin
            // A transfer in IDLE or on the last bit restarts the frame with no gap.
            state_d      = SHIFT;
            shreg_d      = din;
            cnt_d        = '0;
            dout_d       = LSB_FIRST ? din[0] : din[WIDTH-1];
            dout_valid_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (!last_bit) begin
                // The bit now on dout is consumed; the neighbour moves to the output end.
                shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                dout_d  = LSB_FIRST ? shreg_q[1] : shreg_q[WIDTH-2];
                cnt_d   = cnt_q + 1'b1;
            end else begin
                state_d      = IDLE;
                dout_d       = 1'b0;
                dout_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear; a frame in progress is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Purpose: directed self-checking bench for piso_serializer (LSB-first and MSB-first instances).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercised via ignored offers while busy and back-to-back acceptance on the last bit.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic [3:0] din;
    logic       lr_l, dout_l, dv_l, busy_l, done_l;
    logic       lr_m, dout_m, dv_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .din       (din),
        .load_ready(lr_l),
        .dout      (dout_l),
        .dout_valid(dv_l),
        .busy      (busy_l),
        .done      (done_l)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .din       (din),
        .load_ready(lr_m),
        .dout      (dout_m),
        .dout_valid(dv_m),
        .busy      (busy_m),
        .done      (done_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; din = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout_l, dv_l, busy_l, done_l, lr_l} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_hold: got dout,dv,busy,done,rdy=%b expected 00001", {dout_l, dv_l, busy_l, done_l, lr_l});
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dout_l, dv_l, busy_l, done_l, lr_l} !== 5'b00001) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %b expected 00001", i, {dout_l, dv_l, busy_l, done_l, lr_l});
            end
        end
        step();
    endtask

    task automatic test_single();
        logic [3:0] w;
        w = 4'hE;
        load_valid = 1'b1; din = w;
        @(negedge clk);
        checks++;
        if (lr_l !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_idle: got %b expected 1", lr_l);
        end
        step();
        load_valid = 1'b0; din = 4'h3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({dout_l, dv_l, busy_l, done_l, lr_l} !== {w[k], 1'b1, 1'b1, (k == 3), (k == 3)}) begin
                errors++;
                $display("FAIL single_bit%0d: got dout,dv,busy,done,rdy=%b expected %b", k,
                         {dout_l, dv_l, busy_l, done_l, lr_l}, {w[k], 1'b1, 1'b1, (k == 3), (k == 3)});
            end
        end
        @(negedge clk);
        checks++;
        if ({dout_l, dv_l, busy_l, done_l, lr_l} !== 5'b00001) begin
            errors++;
            $display("FAIL single_return_idle: got %b expected 00001", {dout_l, dv_l, busy_l, done_l, lr_l});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits;
        exp_bits = 8'b0101_1110; // bit k = k-th serial bit: 0,1,1,1,1,0,1,0
        load_valid = 1'b1; din = 4'hE;
        step();
        din = 4'h5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({dout_l, dv_l, done_l} !== {exp_bits[k], 1'b1, (k == 3 || k == 7)}) begin
                errors++;
                $display("FAIL b2b_bit%0d: got dout,dv,done=%b expected %b", k,
                         {dout_l, dv_l, done_l}, {exp_bits[k], 1'b1, (k == 3 || k == 7)});
            end
            if (k == 3) begin
                step();
                load_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({dv_l, busy_l} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: got dv,busy=%b expected 00", {dv_l, busy_l});
        end
        step();
    endtask

    task automatic test_msb_first();
        logic [3:0] exp_bits;
        exp_bits = 4'b0111; // serial order 1,1,1,0
        load_valid = 1'b1; din = 4'hE;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({dout_m, dv_m, done_m} !== {exp_bits[k], 1'b1, (k == 3)}) begin
                errors++;
                $display("FAIL msb_bit%0d: got dout,dv,done=%b expected %b", k,
                         {dout_m, dv_m, done_m}, {exp_bits[k], 1'b1, (k == 3)});
            end
        end
        @(negedge clk);
        checks++;
        if ({dv_m, busy_m} !== 2'b00) begin
            errors++;
            $display("FAIL msb_end: got dv,busy=%b expected 00", {dv_m, busy_m});
        end
        step();
    endtask

    task automatic test_interference();
        logic [7:0] exp_bits;
        exp_bits = 8'b0000_1110; // 0,1,1,1 then 0,0,0,0
        load_valid = 1'b1; din = 4'hE;
        step();
        for (int k = 0; k < 8; k++) begin
            load_valid = (k == 0 || k == 1 || k == 3);
            din = 4'h0;
            @(negedge clk);
            checks++;
            if ({dout_l, dv_l, done_l} !== {exp_bits[k], 1'b1, (k == 3 || k == 7)}) begin
                errors++;
                $display("FAIL interf_bit%0d: got dout,dv,done=%b expected %b", k,
                         {dout_l, dv_l, done_l}, {exp_bits[k], 1'b1, (k == 3 || k == 7)});
            end
            if (k < 3) begin
                checks++;
                if (lr_l !== 1'b0) begin
                    errors++;
                    $display("FAIL interf_ready%0d: got %b expected 0", k, lr_l);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({dv_l, busy_l} !== 2'b00) begin
            errors++;
            $display("FAIL interf_end: got dv,busy=%b expected 00", {dv_l, busy_l});
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] w;
        load_valid = 1'b1; din = 4'hE;
        step();
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_l, dv_l, busy_l, done_l, lr_l} !== 5'b00001) begin
            errors++;
            $display("FAIL midrst_async: got %b expected 00001", {dout_l, dv_l, busy_l, done_l, lr_l});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dv_l, done_l} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_hold%0d: got dv,done=%b expected 00", i, {dv_l, done_l});
            end
        end
        step();
        rst_n = 1'b1;
        w = 4'h9;
        load_valid = 1'b1; din = w;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({dout_l, dv_l, done_l} !== {w[k], 1'b1, (k == 3)}) begin
                errors++;
                $display("FAIL midrst_bit%0d: got dout,dv,done=%b expected %b", k,
                         {dout_l, dv_l, done_l}, {w[k], 1'b1, (k == 3)});
            end
        end
        @(negedge clk);
        checks++;
        if ({dout_l, dv_l, busy_l} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_end: got dout,dv,busy=%b expected 000", {dout_l, dv_l, busy_l});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_msb_first();
        test_interference();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
